// File: rtl/smem_filter_fifo.sv
// smem_filter_fifo: filters SMEM records by length and occupancy and buffers survivors
// in a first-word-fall-through FIFO, emitting one tlast beat per read (marker if the last record is dropped).
module smem_filter_fifo #(
  parameter int KLS_W = 40,
  parameter int POS_W = 8,
  parameter int DEPTH = 16,
  localparam int REC_W = 3*KLS_W + 2*POS_W,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [REC_W-1:0] s_axis_tdata,
  input  logic             s_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [REC_W-1:0] m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  input  logic [POS_W-1:0] min_mlen_in,
  input  logic             min_mlen_valid,
  input  logic [KLS_W-1:0] max_occ_in,
  input  logic             max_occ_valid,
  output logic [15:0]      kept_cnt,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      read_cnt,
  output logic [LW-1:0]    level
);
  logic [REC_W+1:0] mem_q [DEPTH];
  logic [REC_W+1:0] head;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [POS_W-1:0] min_mlen_q, min_mlen_d, qbeg, qend, len;
  logic [KLS_W-1:0] max_occ_q, max_occ_d, s_val;
  logic [15:0]      kept_q, kept_d, drop_q, drop_d, read_q, read_d;
  logic             acc, keep, push, pop;
  always_comb begin
    qend = s_axis_tdata[POS_W-1:0];
    qbeg = s_axis_tdata[2*POS_W-1:POS_W];
    s_val = s_axis_tdata[2*POS_W +: KLS_W];
    len = qend >= qbeg ? qend - qbeg : '0;
    keep = len >= min_mlen_q && s_val != '0 && s_val <= max_occ_q;
    s_axis_tready = rst_n && level_q < LW'(DEPTH);
    acc = s_axis_tvalid && s_axis_tready;
    push = acc && (keep || s_axis_tlast);
    m_axis_tvalid = level_q != '0;
    pop = m_axis_tvalid && m_axis_tready;
    head = mem_q[rptr_q];
    m_axis_tdata = head[REC_W+1:2];
    m_axis_tlast = head[1];
    m_axis_tuser = head[0];
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    level_d = level_q + LW'(push) - LW'(pop);
    min_mlen_d = min_mlen_valid ? min_mlen_in : min_mlen_q;
    max_occ_d = max_occ_valid ? max_occ_in : max_occ_q;
    kept_d = kept_q + 16'(acc && keep && kept_q != '1);
    drop_d = drop_q + 16'(acc && !keep && drop_q != '1);
    read_d = read_q + 16'(acc && s_axis_tlast && read_q != '1);
    kept_cnt = kept_q;
    drop_cnt = drop_q;
    read_cnt = read_q;
    level = level_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      min_mlen_q <= POS_W'(19);
      max_occ_q <= KLS_W'(500);
      kept_q <= '0;
      drop_q <= '0;
      read_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      min_mlen_q <= min_mlen_d;
      max_occ_q <= max_occ_d;
      kept_q <= kept_d;
      drop_q <= drop_d;
      read_q <= read_d;
    end
  end
  // storage is not reset; a dropped last record becomes an all-zero marker with tuser set
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {keep ? s_axis_tdata : '0, s_axis_tlast, !keep};
  end
endmodule

// File: tb/tb_smem_filter_fifo.sv
// tb_smem_filter_fifo: directed and randomized stimulus against smem_filter_fifo,
// with an expected-response queue checked by an independent output monitor.
module tb_smem_filter_fifo;
  localparam int KLS_W = 40;
  localparam int POS_W = 8;
  localparam int REC_W = 3*KLS_W + 2*POS_W;
  logic             clk = 0;
  logic             rst_n = 0;
  logic             s_axis_tvalid = 0, s_axis_tready, s_axis_tlast = 0;
  logic [REC_W-1:0] s_axis_tdata = '0;
  logic             m_axis_tvalid, m_axis_tready = 0, m_axis_tlast, m_axis_tuser;
  logic [REC_W-1:0] m_axis_tdata;
  logic [POS_W-1:0] min_mlen_in = '0;
  logic             min_mlen_valid = 0;
  logic [KLS_W-1:0] max_occ_in = '0;
  logic             max_occ_valid = 0;
  logic [15:0]      kept_cnt, drop_cnt, read_cnt;
  logic [4:0]       level;
  int checks = 0, failures = 0, last_cnt = 0;
  bit rand_rdy = 0;
  logic [REC_W+1:0] expq [$];

  smem_filter_fifo dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .min_mlen_in(min_mlen_in), .min_mlen_valid(min_mlen_valid),
    .max_occ_in(max_occ_in), .max_occ_valid(max_occ_valid),
    .kept_cnt(kept_cnt), .drop_cnt(drop_cnt), .read_cnt(read_cnt), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) m_axis_tready = ($urandom_range(0, 3) == 0);
  end

  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL monitor_unexpected act=%0h exp=none", {m_axis_tdata, m_axis_tlast, m_axis_tuser});
      end else begin
        logic [REC_W+1:0] e;
        e = expq.pop_front();
        if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== e) begin
          failures++;
          $display("FAIL monitor_beat act=%0h exp=%0h", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, e);
        end
      end
      if (m_axis_tlast) last_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mk(input logic [KLS_W-1:0] k, l, s, input logic [POS_W-1:0] qb, qe);
    return {k, l, s, qb, qe};
  endfunction

  function automatic bit model_keep(input int qb, qe, input logic [KLS_W-1:0] s);
    int len;
    len = (qe > qb) ? qe - qb : 0;
    return len >= 19 && s != 0 && s <= 500;
  endfunction

  task automatic send(input logic [REC_W-1:0] d, input logic last, input bit keep);
    int n = 0;
    s_axis_tvalid = 1;
    s_axis_tdata = d;
    s_axis_tlast = last;
    @(negedge clk);
    while (!s_axis_tready && n < 300) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!s_axis_tready) begin
      failures++;
      $display("FAIL send_accept act=stalled exp=accepted");
    end else if (keep || last) begin
      expq.push_back(keep ? {d, last, 1'b0} : {{REC_W{1'b0}}, 1'b1, 1'b1});
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((expq.size() != 0 || m_axis_tvalid) && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue", expq.size(), 0);
    chk("drain_level", level, 0);
  endtask

  task automatic rand_read(input int idle_max);
    int nb;
    nb = $urandom_range(1, 3);
    for (int b = 0; b < nb; b++) begin
      int qb, qe, sel;
      logic [KLS_W-1:0] s;
      qb = $urandom_range(0, 255);
      qe = $urandom_range(0, 255);
      sel = $urandom_range(0, 9);
      s = sel == 0 ? '0 : sel == 1 ? KLS_W'($urandom_range(501, 1000)) : KLS_W'($urandom_range(1, 500));
      repeat ($urandom_range(0, idle_max)) begin
        @(posedge clk);
        #1;
      end
      send(mk({8'h0, 32'($urandom)}, {8'h0, 32'($urandom)}, s, POS_W'(qb), POS_W'(qe)),
           b == nb - 1, model_keep(qb, qe, s));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_level", level, 0);
    chk("rst_kept", kept_cnt, 0);
    chk("rst_read", read_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    m_axis_tready = 1;
    // single kept record visible one edge after acceptance
    send(mk(40'h11, 40'h22, 40'd3, 8'd10, 8'd35), 1, 1);
    chk("latency_tvalid", m_axis_tvalid, 1);
    chk("latency_level", level, 1);
    drain(20);
    chk("t1_kept", kept_cnt, 1);
    chk("t1_read", read_cnt, 1);
    // short seed then over-occurring last seed: one marker beat
    send(mk(40'h1, 40'h2, 40'd3, 8'd10, 8'd20), 0, 0);
    send(mk(40'h3, 40'h4, 40'd600, 8'd0, 8'd30), 1, 0);
    drain(20);
    chk("t2_drop", drop_cnt, 2);
    chk("t2_read", read_cnt, 2);
    chk("t2_kept", kept_cnt, 1);
    // fill to full with the consumer stalled; pointers wrap past the end
    m_axis_tready = 0;
    for (int i = 0; i < 16; i++) send(mk(40'(i + 100), 40'(i), 40'd3, 8'd0, 8'd30), i % 4 == 3, 1);
    @(negedge clk);
    chk("full_tready", s_axis_tready, 0);
    chk("full_level", level, 16);
    @(posedge clk);
    #1;
    chk("full_stays", s_axis_tready, 0);
    m_axis_tready = 1;
    @(posedge clk);
    #1;
    m_axis_tready = 0;
    chk("after_pop_tready", s_axis_tready, 1);
    chk("after_pop_level", level, 15);
    send(mk(40'd200, 40'd0, 40'd3, 8'd0, 8'd30), 1, 1);
    chk("refill_level", level, 16);
    m_axis_tready = 1;
    drain(40);
    // threshold strobe applies only from the following beat
    max_occ_in = 40'd2;
    max_occ_valid = 1;
    send(mk(40'h5, 40'h6, 40'd3, 8'd0, 8'd30), 1, 1);
    max_occ_valid = 0;
    send(mk(40'h5, 40'h6, 40'd3, 8'd0, 8'd30), 1, 0);
    drain(20);
    chk("t4_kept", kept_cnt, 19);
    chk("t4_drop", drop_cnt, 3);
    chk("t4_read", read_cnt, 9);
    @(posedge clk);
    #1;
    rst_n = 0;
    @(negedge clk);
    chk("rst2_tready", s_axis_tready, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    chk("rst2_kept", kept_cnt, 0);
    chk("rst2_drop", drop_cnt, 0);
    chk("rst2_read", read_cnt, 0);
    // randomized traffic at roughly quarter duty on both sides
    last_cnt = 0;
    rand_rdy = 1;
    for (int r = 0; r < 1000; r++) rand_read(5);
    drain(3000);
    chk("rand_read_cnt", read_cnt, 1000);
    chk("rand_last_cnt", last_cnt, 1000);
    // reset in the middle of a stream discards everything
    for (int r = 0; r < 15; r++) rand_read(0);
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    expq.delete();
    chk("midrst_level", level, 0);
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_kept", kept_cnt, 0);
    chk("midrst_drop", drop_cnt, 0);
    chk("midrst_read", read_cnt, 0);
    rand_rdy = 0;
    m_axis_tready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_idle", m_axis_tvalid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
